ip_rd_seq: RTL
==============

IP_RD_SEQ -- requirements
Module: ip_rd_seq

Interface
REQ-001 Parameter FW, default 16, data word width.
REQ-002 Parameter AW, default 15, BRAM address width.
REQ-003 Parameter RL, default 1, BRAM read latency in cycles; legal values are 1 and 2.
REQ-004 Parameter DEPTH, default 4, output buffer depth; must be a power of 2 and at least RL+2.
REQ-005 Parameters PW=12, CW=6, SW=5 set the pixel, channel and sector counter widths.
REQ-006 Port list (name, direction, width, meaning) SHALL be:
 clk_i  in  1  clock
 rstn_i  in  1  reset, asynchronous, active-low
 start_i  in  1  single-cycle start pulse
 cfg_pix_end_i  in  PW  last pixel index
 cfg_ch_end_i  in  CW  last channel index
 cfg_sec_end_i  in  SW  last sector index
 cfg_base_i  in  AW  start address
 cfg_pix_stride_i  in  AW  address step per pixel
 cfg_sec_stride_i  in  AW  address step per sector
 busy_o  out  1  sequence in progress
 done_o  out  1  one-cycle pulse at sequence completion
 rd_en_o  out  1  BRAM read enable
 rd_addr_o  out  AW  BRAM read address
 rd_data_i  in  FW  BRAM read data, valid RL cycles after rd_en_o
 data_o  out  FW  output word
 data_valid_o  out  1  data_o is valid
 data_ready_i  in  1  downstream accepts the word
 block_last_o  out  1  data_o is the last word of a sector (switch block)

Function
REQ-007 Configuration inputs SHALL be latched on start_i while in IDLE and ignored at all other times.
REQ-008 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on start_i.
- RUN->DRAIN after the last read is issued.
- DRAIN->DONE when the buffer is empty and no read is in flight.
- DONE->IDLE after exactly one cycle.
REQ-009 start_i asserted outside IDLE SHALL be ignored.
REQ-010 Iteration order SHALL be pixel innermost, then channel, then sector.
REQ-011 The total read count SHALL be (pix_end+1)*(ch_end+1)*(sec_end+1).
REQ-012 The read address SHALL be base + sec*sec_stride + pix*pix_stride + ch, modulo 2^AW.
REQ-013 Addresses SHALL be generated by incremental accumulators only, with no multipliers.
REQ-014 rd_en_o SHALL be asserted in RUN only when (buffer occupancy + reads in flight) < DEPTH; counters advance only on cycles where rd_en_o=1.
REQ-015 Each returned word SHALL be written to the FIFO RL cycles after its rd_en_o, tagged with a last bit; the tag is 1 when pix=pix_end and ch=ch_end.
REQ-016 data_valid_o SHALL equal "FIFO not empty"; a word is popped when data_valid_o and data_ready_i are both 1.
REQ-017 data_o and block_last_o SHALL be driven from the FIFO head.
REQ-018 FIFO push and pop in the same cycle SHALL keep the occupancy unchanged; the FIFO SHALL never overflow.
REQ-019 With data_ready_i held at 1, throughput SHALL be one word per cycle, and the first data_valid_o SHALL occur RL+1 cycles after start_i.
REQ-020 busy_o SHALL be 1 in RUN and DRAIN.
REQ-021 done_o SHALL be 1 only in DONE, i.e. one cycle after the final pop.
REQ-022 All-zero end values SHALL yield exactly one read, at address base.

Reset
REQ-023 Asynchronous assertion of rstn_i SHALL force IDLE, clear all counters, accumulators, the FIFO and the in-flight pipeline, and set every output to 0.
REQ-024 Reset asserted mid-sequence SHALL discard the in-flight data; after release, no stale word may appear on data_o.
REQ-025 After reset release the block SHALL stay idle until the next start_i.

Structure
REQ-026 The FSM state encoding and the default values of PW/CW/SW SHALL live in the shared package ip_pkg.
REQ-027 The output buffer SHALL be a separate sub-module ip_rd_fifo (parameters FW+1, DEPTH) with push/pop/full/empty/count ports.
REQ-028 The credit and in-flight counter SHALL remain in ip_rd_seq.

Verification
REQ-029 Config pix_end=48, ch_end=31, sec_end=15, base=0, pix_stride=32, sec_stride=1568, ready=1 -> 25088 words; the address of word n matches the REQ-012 formula; block_last_o pulses 16 times; done_o pulses once.
REQ-030 Config pix_end=4095, ch_end=0, sec_end=0, pix_stride=1, base=100 -> addresses 100..4195; one block_last_o, on the final word.
REQ-031 Config pix_end=7, ready held 0 for 20 cycles -> rd_en_o count stops at DEPTH; on release, all 8 words are delivered in order with no loss or duplication.
REQ-032 Random data_ready_i (50%), RL=2, pix_end=9, ch_end=2, sec_end=1 -> 60 words, correct order, FIFO never overflows.
REQ-033 rstn_i pulsed after 10 reads of a 49-word run -> all outputs are 0 in the same cycle; a new start_i then produces a clean full sequence.
REQ-034 start_i pulsed during RUN with different config values -> no effect on the current sequence.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared types for the ip read sequencer.
// FSM encoding and default counter widths.
package ip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int PW_DEF = 12;
  localparam int CW_DEF = 6;
  localparam int SW_DEF = 5;

endpackage

// File: rtl/ip_rd_fifo.sv
// Output buffer for the read sequencer.
// Head is forced to zero while empty so no stale word is visible.
module ip_rd_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4,
  localparam int PTR = $clog2(DEPTH),
  localparam int CNTW = PTR + 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            push_i,
  input  logic [W-1:0]    din_i,
  input  logic            pop_i,
  output logic [W-1:0]    dout_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CNTW-1:0] count_o
);

  logic [W-1:0]    mem [DEPTH];
  logic [PTR-1:0]  wptr;
  logic [PTR-1:0]  rptr;
  logic [CNTW-1:0] cnt;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (cnt == CNTW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem[rptr];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= din_i;
        wptr      <= wptr + PTR'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PTR'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ip_rd_seq.sv
// BRAM read sequencer: sector/channel/pixel address walk
// with credit-based flow control into a small output FIFO.
module ip_rd_seq
  import ip_pkg::*;
#(
  parameter int FW = 16,
  parameter int AW = 15,
  parameter int RL = 1,
  parameter int DEPTH = 4,
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic [PW-1:0] cfg_pix_end_i,
  input  logic [CW-1:0] cfg_ch_end_i,
  input  logic [SW-1:0] cfg_sec_end_i,
  input  logic [AW-1:0] cfg_base_i,
  input  logic [AW-1:0] cfg_pix_stride_i,
  input  logic [AW-1:0] cfg_sec_stride_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [FW-1:0] rd_data_i,
  output logic [FW-1:0] data_o,
  output logic          data_valid_o,
  input  logic          data_ready_i,
  output logic          block_last_o
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  state_t state_q, state_nx;

  logic [PW-1:0]   pe_q, pix_q;
  logic [CW-1:0]   ce_q, ch_q;
  logic [SW-1:0]   se_q, sec_q;
  logic [AW-1:0]   ps_q, ss_q;
  logic [AW-1:0]   addr_q, ch_base_q, sec_base_q;
  logic [AW-1:0]   nx_ch_base, nx_sec_base;
  logic [CNTW-1:0] infl_q, count;
  logic [RL-1:0]   pv_q, pl_q;
  logic [FW:0]     head;
  logic            push, pop, full, empty;
  logic            pix_wrap, ch_wrap, sec_wrap;
  logic            credit_ok, drain_ok;

  assign pix_wrap    = (pix_q == pe_q);
  assign ch_wrap     = (ch_q == ce_q);
  assign sec_wrap    = (sec_q == se_q);
  assign nx_ch_base  = ch_base_q + AW'(1);
  assign nx_sec_base = sec_base_q + ss_q;

  // Reserve a FIFO slot for every read still in the BRAM pipeline.
  assign credit_ok = ({1'b0, count} + {1'b0, infl_q})
                     < (CNTW + 1)'(DEPTH);
  assign rd_en_o   = (state_q == RUN) && credit_ok && !full;
  assign rd_addr_o = addr_q;

  assign push         = pv_q[RL-1];
  assign data_valid_o = !empty;
  assign pop          = data_valid_o && data_ready_i;
  assign data_o       = head[FW-1:0];
  assign block_last_o = head[FW];

  // Leave DRAIN in the cycle of the final pop.
  assign drain_ok = (infl_q == '0) &&
                    (empty || (count == CNTW'(1) && pop));

  assign busy_o = (state_q == RUN) || (state_q == DRAIN);
  assign done_o = (state_q == DONE);

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_nx = RUN;
      RUN:   if (rd_en_o && pix_wrap && ch_wrap && sec_wrap)
               state_nx = DRAIN;
      DRAIN: if (drain_ok) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_nx;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pe_q       <= '0;
      ce_q       <= '0;
      se_q       <= '0;
      ps_q       <= '0;
      ss_q       <= '0;
      pix_q      <= '0;
      ch_q       <= '0;
      sec_q      <= '0;
      addr_q     <= '0;
      ch_base_q  <= '0;
      sec_base_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      pe_q       <= cfg_pix_end_i;
      ce_q       <= cfg_ch_end_i;
      se_q       <= cfg_sec_end_i;
      ps_q       <= cfg_pix_stride_i;
      ss_q       <= cfg_sec_stride_i;
      pix_q      <= '0;
      ch_q       <= '0;
      sec_q      <= '0;
      addr_q     <= cfg_base_i;
      ch_base_q  <= cfg_base_i;
      sec_base_q <= cfg_base_i;
    end else if (rd_en_o) begin
      if (!pix_wrap) begin
        pix_q  <= pix_q + PW'(1);
        addr_q <= addr_q + ps_q;
      end else begin
        pix_q <= '0;
        if (!ch_wrap) begin
          ch_q      <= ch_q + CW'(1);
          ch_base_q <= nx_ch_base;
          addr_q    <= nx_ch_base;
        end else begin
          ch_q <= '0;
          if (!sec_wrap) begin
            sec_q      <= sec_q + SW'(1);
            sec_base_q <= nx_sec_base;
            ch_base_q  <= nx_sec_base;
            addr_q     <= nx_sec_base;
          end else begin
            sec_q <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pv_q   <= '0;
      pl_q   <= '0;
      infl_q <= '0;
    end else begin
      pv_q <= (pv_q << 1) | RL'(rd_en_o);
      pl_q <= (pl_q << 1) | RL'(pix_wrap && ch_wrap);
      case ({rd_en_o, push})
        2'b10:   infl_q <= infl_q + CNTW'(1);
        2'b01:   infl_q <= infl_q - CNTW'(1);
        default: infl_q <= infl_q;
      endcase
    end
  end

  ip_rd_fifo #(
    .W     (FW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .din_i   ({pl_q[RL-1], rd_data_i}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule
